dendrite_accum: RTL and testbench

DENDRITE_ACCUM -- requirements
Module: dendrite_accum

---
 rtl/dendrite_accum.sv | 161 ++++++++++++++++
 tb/tb_dendrite_accum.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dendrite_accum.sv
// Dendrite charge accumulator: per-neuron signed charge memory with a
// 2-stage saturating read/modify/write path and an end-of-timestep drain
// that streams out and clears every non-zero entry.
module dendrite_accum #(
    parameter int unsigned NUM_NEURONS = 256,
    parameter int unsigned CHARGE_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [7:0]                 dend_addr,
    input  logic signed [8:0]          dend_charge,
    input  logic                       dend_vld,
    output logic                       dend_rdy,
    input  logic                       step,
    output logic [7:0]                 neuron_addr,
    output logic signed [CHARGE_W-1:0] neuron_charge,
    output logic                       neuron_vld,
    input  logic                       neuron_rdy,
    output logic                       drain_done,
    output logic                       busy
);
    localparam int unsigned AW = 8;
    localparam int unsigned SW = CHARGE_W + 1;
    localparam logic [AW-1:0] LAST = AW'(NUM_NEURONS - 1);
    localparam logic [CHARGE_W-1:0] SAT_MAX = {1'b0, {(CHARGE_W-1){1'b1}}};
    localparam logic [CHARGE_W-1:0] SAT_MIN = {1'b1, {(CHARGE_W-1){1'b0}}};

    typedef enum logic [2:0] {CLEAR, ACCUM, FLUSH, DRAIN, DONE} state_t;

    state_t              state;
    logic [AW-1:0]       idx;
    logic [CHARGE_W-1:0] mem [NUM_NEURONS];

    logic                s1_vld;
    logic [AW-1:0]       s1_addr;
    logic [8:0]          s1_charge;
    logic [CHARGE_W-1:0] s1_rdata;

    logic [SW-1:0]       wide_sum;
    logic [CHARGE_W-1:0] sat_sum;
    logic [CHARGE_W-1:0] rd_data;
    logic                accept;

    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [CHARGE_W-1:0] mem_wdata;

    assign dend_rdy = (state == ACCUM) && enable && !step;
    assign busy     = (state != ACCUM);
    assign accept   = dend_vld && dend_rdy;

    // Stage 2: sign-extended add with saturation to the charge range
    always_comb begin
        wide_sum = {s1_rdata[CHARGE_W-1], s1_rdata} + {{(SW-9){s1_charge[8]}}, s1_charge};
        if (wide_sum[SW-1] != wide_sum[SW-2]) begin
            sat_sum = wide_sum[SW-1] ? SAT_MIN : SAT_MAX;
        end else begin
            sat_sum = wide_sum[CHARGE_W-1:0];
        end
    end

    // Stage 1 read: take the stage-2 result when it targets the same entry
    assign rd_data = (s1_vld && (s1_addr == dend_addr)) ? sat_sum : mem[dend_addr];

    // Single write port shared by clear, accumulate and drain-clear
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = s1_addr;
        mem_wdata = sat_sum;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = idx;
            mem_wdata = '0;
        end else if (s1_vld) begin
            mem_we    = 1'b1;
        end else if (neuron_vld && neuron_rdy) begin
            mem_we    = 1'b1;
            mem_waddr = neuron_addr;
            mem_wdata = '0;
        end
    end

    // Charge memory
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM, accumulate pipeline register and registered drain outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= CLEAR;
            idx           <= '0;
            s1_vld        <= 1'b0;
            s1_addr       <= '0;
            s1_charge     <= '0;
            s1_rdata      <= '0;
            neuron_vld    <= 1'b0;
            neuron_addr   <= '0;
            neuron_charge <= '0;
            drain_done    <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            s1_vld     <= accept;
            if (accept) begin
                s1_addr   <= dend_addr;
                s1_charge <= dend_charge;
                s1_rdata  <= rd_data;
            end
            case (state)
                CLEAR: begin
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= ACCUM;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                ACCUM: begin
                    if (step && enable) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    idx   <= '0;
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (neuron_vld) begin
                        if (neuron_rdy) begin
                            neuron_vld <= 1'b0;
                            if (idx == LAST) begin
                                state      <= DONE;
                                drain_done <= 1'b1;
                            end else begin
                                idx <= idx + AW'(1);
                            end
                        end
                    end else if (mem[idx] != '0) begin
                        neuron_vld    <= 1'b1;
                        neuron_addr   <= idx;
                        neuron_charge <= mem[idx];
                    end else if (idx == LAST) begin
                        state      <= DONE;
                        drain_done <= 1'b1;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                DONE: begin
                    state <= ACCUM;
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dendrite_accum.sv
// Self-checking bench for dendrite_accum: table of accumulate/drain vectors,
// hand-written corner sequences and randomized traffic against a model.
module tb_dendrite_accum;
    logic              clk;
    logic              reset;
    logic              enable;
    logic [7:0]        dend_addr;
    logic signed [8:0] dend_charge;
    logic              dend_vld;
    logic              dend_rdy;
    logic              step;
    logic [7:0]        neuron_addr;
    logic signed [15:0] neuron_charge;
    logic              neuron_vld;
    logic              neuron_rdy;
    logic              drain_done;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    int model [256];

    typedef struct {
        int addr;
        int charge;
        int count;
        int expect_charge;
    } vec_t;
    vec_t vecs [10];

    dendrite_accum dut (
        .clk(clk), .reset(reset), .enable(enable),
        .dend_addr(dend_addr), .dend_charge(dend_charge), .dend_vld(dend_vld),
        .dend_rdy(dend_rdy), .step(step), .neuron_addr(neuron_addr),
        .neuron_charge(neuron_charge), .neuron_vld(neuron_vld),
        .neuron_rdy(neuron_rdy), .drain_done(drain_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference accumulate: add then clamp to the 16-bit signed range
    task automatic model_add(input int a, input int c);
        int v;
        v = model[a] + c;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        model[a] = v;
    endtask

    task automatic do_reset();
        int cnt;
        bit got;
        reset = 1'b1; enable = 1'b1; step = 1'b0; neuron_rdy = 1'b1;
        dend_vld = 1'b1; dend_addr = 8'd3; dend_charge = 9'sd7;
        repeat (3) @(negedge clk);
        #1;
        chk("rst dend_rdy", dend_rdy, 0);
        chk("rst neuron_vld", neuron_vld, 0);
        chk("rst neuron_addr", neuron_addr, 0);
        chk("rst neuron_charge", neuron_charge, 0);
        chk("rst drain_done", drain_done, 0);
        chk("rst busy", busy, 1);
        for (int i = 0; i < 256; i++) model[i] = 0;
        @(negedge clk);
        reset = 1'b0;
        cnt = 0; got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (dend_rdy) got = 1'b1;
        end
        dend_vld = 1'b0;
        neuron_rdy = 1'b0;
        chk("clear length", cnt, 256);
    endtask

    task automatic send(input int a, input int c);
        @(negedge clk);
        dend_vld = 1'b1; dend_addr = 8'(a); dend_charge = 9'(c);
        #1;
        chk("send dend_rdy", dend_rdy, 1);
        if (dend_rdy) model_add(a, c);
    endtask

    task automatic idle();
        @(negedge clk);
        dend_vld = 1'b0;
    endtask

    // Drain and compare against the model; returns count and first entry
    task automatic run_drain(input string name, input int stall, input bit rand_rdy,
                             input int step_at, input bit start,
                             output int n_got, output int fa, output int fc);
        int  exp_a [$];
        int  exp_c [$];
        int  got_a [$];
        int  got_c [$];
        bit  prev_stall, done_seen;
        int  pa, pc, stall_left;
        for (int i = 0; i < 256; i++) begin
            if (model[i] != 0) begin
                exp_a.push_back(i); exp_c.push_back(model[i]); model[i] = 0;
            end
        end
        if (start) begin
            @(negedge clk); step = 1'b1; dend_vld = 1'b0;
            @(negedge clk); step = 1'b0;
        end
        done_seen = 1'b0; prev_stall = 1'b0; pa = 0; pc = 0; stall_left = stall;
        for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
            if (neuron_vld && stall_left > 0) begin
                neuron_rdy = 1'b0; stall_left--;
            end else begin
                neuron_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            step = (cyc == step_at);
            #1;
            if (prev_stall) begin
                chk({name, " hold vld"}, neuron_vld, 1);
                chk({name, " hold addr"}, neuron_addr, pa);
                chk({name, " hold charge"}, neuron_charge, pc);
            end
            if (neuron_vld && neuron_rdy) begin
                got_a.push_back(int'(neuron_addr)); got_c.push_back(int'(neuron_charge));
            end
            prev_stall = neuron_vld && !neuron_rdy;
            pa = int'(neuron_addr); pc = int'(neuron_charge);
            if (drain_done) begin
                done_seen = 1'b1;
                chk({name, " vld at done"}, neuron_vld, 0);
            end
            @(negedge clk);
        end
        step = 1'b0;
        neuron_rdy = 1'b0;
        chk({name, " drain_done seen"}, done_seen, 1);
        #1;
        chk({name, " back to accum"}, busy, 0);
        chk({name, " count"}, got_a.size(), exp_a.size());
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            chk({name, " addr"}, got_a[i], exp_a[i]);
            chk({name, " charge"}, got_c[i], exp_c[i]);
        end
        n_got = got_a.size();
        fa = (n_got > 0) ? got_a[0] : -1;
        fc = (n_got > 0) ? got_c[0] : 0;
    endtask

    task automatic random_round(input int n, input int lo, input int hi);
        int pool [4];
        int a, c;
        pool[0] = 0; pool[3] = 255;
        pool[1] = int'($urandom_range(1, 254)); pool[2] = int'($urandom_range(1, 254));
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            enable   = ($urandom_range(0, 9) != 0);
            dend_vld = ($urandom_range(0, 3) != 0);
            a = pool[$urandom_range(0, 3)];
            c = lo + int'($urandom_range(0, hi - lo));
            dend_addr = 8'(a); dend_charge = 9'(c);
            #1;
            chk("rand dend_rdy", dend_rdy, enable);
            if (dend_vld && dend_rdy) model_add(a, c);
        end
        @(negedge clk);
        dend_vld = 1'b0; enable = 1'b1;
    endtask

    initial begin
        int  n_got, fa, fc;
        bit  seen;
        vecs[0] = '{5,    3,   1,   3};
        vecs[1] = '{7,  255, 200,  32767};
        vecs[2] = '{7, -256, 200, -32768};
        vecs[3] = '{0,   -1,   4,  -4};
        vecs[4] = '{255, 100,  3,  300};
        vecs[5] = '{128,   0,  5,  0};
        vecs[6] = '{10,  255, 128, 32640};
        vecs[7] = '{10,  255, 129, 32767};
        vecs[8] = '{3,  -256, 128, -32768};
        vecs[9] = '{3,  -256, 127, -32512};

        do_reset();
        run_drain("empty", 0, 0, -1, 1, n_got, fa, fc);
        chk("empty drain outputs", n_got, 0);

        send(5, 3); send(5, -1); send(5, 10); idle();
        run_drain("b2b", 0, 0, -1, 1, n_got, fa, fc);
        chk("b2b count", n_got, 1);
        chk("b2b addr", fa, 5);
        chk("b2b charge", fc, 12);

        for (int v = 0; v < 10; v++) begin
            for (int k = 0; k < vecs[v].count; k++) send(vecs[v].addr, vecs[v].charge);
            idle();
            run_drain($sformatf("vec%0d", v), 0, 0, -1, 1, n_got, fa, fc);
            chk($sformatf("vec%0d count", v), n_got, (vecs[v].expect_charge != 0) ? 1 : 0);
            chk($sformatf("vec%0d addr", v), fa, (vecs[v].expect_charge != 0) ? vecs[v].addr : -1);
            chk($sformatf("vec%0d charge", v), fc, vecs[v].expect_charge);
        end

        send(2, 11); send(9, -22); send(255, 33); idle();
        run_drain("stall", 10, 0, -1, 1, n_got, fa, fc);
        chk("stall count", n_got, 3);
        run_drain("second", 0, 0, -1, 1, n_got, fa, fc);
        chk("second drain outputs", n_got, 0);

        // step with enable low is dropped, not queued
        send(40, 9); idle();
        @(negedge clk); enable = 1'b0; step = 1'b1; #1;
        chk("en low rdy", dend_rdy, 0);
        @(negedge clk); step = 1'b0; #1;
        chk("en low no drain", busy, 0);
        @(negedge clk); enable = 1'b1; #1;
        chk("en low not queued", busy, 0);

        // step together with dend_vld: no transfer, drain starts; step in DRAIN ignored
        send(30, 7);
        @(negedge clk);
        step = 1'b1; dend_vld = 1'b1; dend_addr = 8'd20; dend_charge = 9'sd50;
        #1;
        chk("step rdy", dend_rdy, 0);
        @(negedge clk); step = 1'b0; dend_vld = 1'b0; #1;
        chk("step busy", busy, 1);
        run_drain("step", 0, 0, 20, 0, n_got, fa, fc);
        chk("step count", n_got, 2);
        repeat (3) @(negedge clk);
        #1;
        chk("step ignored in drain", busy, 0);

        // reset mid-drain after addr 2 has been handed off
        send(2, 40); send(9, 5); idle();
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0; neuron_rdy = 1'b1;
        seen = 1'b0;
        for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
            #1;
            if (neuron_vld && neuron_rdy) begin
                chk("rst mid addr", neuron_addr, 2);
                seen = 1'b1;
            end
            @(negedge clk);
        end
        chk("rst mid handoff", seen, 1);
        do_reset();
        run_drain("after rst", 0, 0, -1, 1, n_got, fa, fc);
        chk("after rst outputs", n_got, 0);

        random_round(300, -256, 255);
        run_drain("rand0", 0, 1, -1, 1, n_got, fa, fc);
        random_round(400, 100, 255);
        run_drain("rand1", 0, 1, -1, 1, n_got, fa, fc);
        random_round(400, -256, -100);
        run_drain("rand2", 0, 1, -1, 1, n_got, fa, fc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
